// File: rtl/dump_pkg.sv
// Shared definitions for the post-halt memory dump engine.
// Holds the FSM state encoding, the halt instruction encodings (also used by
// the core's decoder) and the default pipeline-drain length.
package dump_pkg;

  localparam int unsigned INSTR_W = 16;

  // Halt is opcode 11100 with an all-zero or all-one operand field.
  localparam logic [INSTR_W-1:0] HALT_A = 16'hE000;
  localparam logic [INSTR_W-1:0] HALT_B = 16'hE7FF;

  localparam int unsigned DEF_DRAIN_CYCLES = 10;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } dump_state_t;

  // True when a fetched word matches either halt encoding.
  function automatic logic is_halt(input logic [INSTR_W-1:0] word,
                                   input logic [INSTR_W-1:0] enc_a,
                                   input logic [INSTR_W-1:0] enc_b);
    return (word == enc_a) || (word == enc_b);
  endfunction

endpackage

// File: rtl/halt_dump_unit.sv
// Post-halt memory dump engine.
// Detects a halt instruction, waits for the pipeline to drain, then reads a
// latched address window from data memory and streams the words (optionally
// only the non-zero ones) out on a valid/ready port.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   instr, instr_valid    instruction in decode and its valid qualifier
//   win_lo, win_hi        inclusive dump window, sampled on halt detection
//   halt                  sticky; core freezes fetch while high
//   mem_req, mem_addr     data-memory read strobe and address
//   mem_rdata             read data, valid the cycle after mem_req
//   dump_valid/_addr/_data/_last, dump_ready   output stream
//   done                  sticky; dump complete
module halt_dump_unit
  import dump_pkg::*;
#(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 16,
  parameter int unsigned          DRAIN_CYCLES = dump_pkg::DEF_DRAIN_CYCLES,
  parameter logic [INSTR_W-1:0]   HALT_A       = dump_pkg::HALT_A,
  parameter logic [INSTR_W-1:0]   HALT_B       = dump_pkg::HALT_B,
  parameter bit                   SKIP_ZERO    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic [ADDR_W-1:0]  win_lo,
  input  logic [ADDR_W-1:0]  win_hi,
  output logic               halt,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               dump_valid,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               dump_last,
  input  logic               dump_ready,
  output logic               done
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  dump_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] lo, lo_nxt;
  logic [ADDR_W-1:0] hi, hi_nxt;
  logic [DATA_W-1:0] hold_nxt;

  logic              halt_nxt;
  logic              done_nxt;
  logic              mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              dump_valid_nxt;
  logic [ADDR_W-1:0] dump_addr_nxt;
  logic [DATA_W-1:0] dump_data_nxt;
  logic              dump_last_nxt;

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      cnt        <= '0;
      addr       <= '0;
      lo         <= '0;
      hi         <= '0;
      halt       <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      addr       <= addr_nxt;
      lo         <= lo_nxt;
      hi         <= hi_nxt;
      halt       <= halt_nxt;
      done       <= done_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      dump_valid <= dump_valid_nxt;
      dump_addr  <= dump_addr_nxt;
      dump_data  <= dump_data_nxt;
      dump_last  <= dump_last_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    lo_nxt    = lo;
    hi_nxt    = hi;
    // dump_data doubles as the holding register for the word being offered.
    hold_nxt  = dump_data;

    unique case (state)
      ST_RUN: begin
        if (instr_valid && is_halt(instr, HALT_A, HALT_B)) begin
          state_nxt = ST_DRAIN;
          lo_nxt    = win_lo;
          hi_nxt    = win_hi;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES);
        end
      end

      ST_DRAIN: begin
        // Leaving on the count of 1 gives exactly DRAIN_CYCLES cycles here.
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          addr_nxt  = lo;
          state_nxt = (lo <= hi) ? ST_READ : ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_READ: begin
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        hold_nxt = mem_rdata;
        if (SKIP_ZERO && (mem_rdata == '0)) begin
          if (addr == hi) begin
            state_nxt = ST_DONE;
          end else begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = ST_READ;
          end
        end else begin
          state_nxt = ST_OUT;
        end
      end

      ST_OUT: begin
        // End test precedes the increment so a window ending at the top
        // address never wraps.
        if (dump_valid && dump_ready) begin
          if (addr == hi) begin
            state_nxt = ST_DONE;
          end else begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = ST_READ;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_DONE;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    halt_nxt       = (state_nxt != ST_RUN);
    done_nxt       = (state_nxt == ST_DONE);
    mem_req_nxt    = (state_nxt == ST_READ);
    mem_addr_nxt   = mem_req_nxt ? addr_nxt : '0;
    dump_valid_nxt = (state_nxt == ST_OUT);
    dump_addr_nxt  = dump_valid_nxt ? addr_nxt : '0;
    dump_data_nxt  = dump_valid_nxt ? hold_nxt : '0;
    dump_last_nxt  = dump_valid_nxt && (addr_nxt == hi_nxt);
  end

endmodule
